reg_bus_responder: RTL
======================

# reg_bus_responder

Bus-side responder for the register/memory request protocol used by the per-operand register managers. Samples single-cycle `read_q`/`write_q` requests on the shared `addr`/`data` bus, serves them from an internal word store after a programmable wait, and answers with a done pulse that re-drives the request address so initiators can match it. Owns `is_bus_busy`, honours the `halt_q`/`rw_halt` read-cancel mechanism, and zero-fills its store after reset.

## Interface
- `DEPTH`, 64: words in the store; power of two, at most 2^`ADDR_SIZE`.
- `WAIT_CYCLES`, 2: cycles between request acceptance and the done cycle; must be at least 0.
- `clk` in 1: clock; all state is updated on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `read_q` in 1: read request; sampled as `=== 1`, so `z` and `x` mean no request.
- `write_q` in 1: write request; same sampling rule as `read_q`.
- `halt_q` in 1: initiator marks its read as cancellable.
- `rw_halt` in 1: a pending writer claims the read address; sampled as `=== 1`.
- `addr` inout `ADDR_SIZE`: request address in; latched address driven out only during the done cycle, otherwise `z`.
- `data` inout `DATA_SIZE`: write data in; read data driven out only during a read done cycle, otherwise `z`.
- `read_dn` out 1: read done strobe.
- `write_dn` out 1: write done strobe.
- `is_bus_busy` out 1: 1 from acceptance through the done cycle, and 1 during the clear sweep.
- `bus_err` out 1: one-cycle pulse on a protocol error.

## Operation
- States:
  - CLEAR: entered from reset; writes 0 to each word, one word per cycle, for `DEPTH` cycles; requests are ignored; then goes to IDLE.
  - IDLE
  - WAIT
  - DONE
  - GAP
- Request handling in IDLE, at the sampling edge:
  - `read_q` and `write_q` both 1: `bus_err`=1, serve the write, drop the read.
  - `read_q` with `halt_q`=1 and `rw_halt`=1 in the same edge: request cancelled, no busy, no done, stay in IDLE.
  - Otherwise latch `addr`, `data` and the operation (rd/wr), set `is_bus_busy`=1, load the wait counter with `WAIT_CYCLES`, go to WAIT. With `WAIT_CYCLES`=0, go directly to DONE.
- WAIT: decrement the counter; at 1, go to DONE.
- DONE, one cycle:
  - Drive `addr` with the latched address.
  - Write: commit the store, then `write_dn`=1.
  - Read: drive `data` with the store word, `read_dn`=1.
  - `is_bus_busy` stays 1. Then go to GAP.
- GAP, one cycle: `is_bus_busy`=0 and all bus outputs `z`, so initiators can withdraw their request. Requests sampled in GAP are ignored. Then go to IDLE.
- Addressing: index = `addr[log2(DEPTH)-1:0]`. If any upper bit is 1 (out of range), a read returns 0, a write is discarded, done still pulses, and `bus_err` pulses in DONE.
- A request arriving in WAIT, DONE or CLEAR: `bus_err`=1 and the request is ignored.
- Reset mid-transaction: the pending operation is abandoned, nothing is committed, the state goes to CLEAR.

## Timing
- Reset values: `read_dn`=0, `write_dn`=0, `bus_err`=0, `is_bus_busy`=1 (CLEAR), `addr`/`data` = `z`.
- Latency from the request edge to the done cycle is `WAIT_CYCLES`+1 edges; default 3.
- Throughput: one transaction per `WAIT_CYCLES`+3 cycles.
- Clear sweep takes `DEPTH` cycles; the first accepted request is at the edge after CLEAR ends.
- All outputs are registered; bus drive enables are derived from the state register only.
- The done strobes are exactly one cycle wide.

## Structure
- State encodings go in `states.v` as `RSP_CLEAR`, `RSP_IDLE`, `RSP_WAIT`, `RSP_DONE`, `RSP_GAP`.
- Widths come from `sizes.v`; no new width constants.
- Natural sub-module: `reg_store`, a synchronous single-port RAM with write enable, `DEPTH` words of `DATA_SIZE`.
- The FSM, counter and tri-state drivers stay in the top module.

## Test plan
- Reset, then 64 cycles: busy stays 1 throughout, drops at cycle 65 of CLEAR exit; a read of address 5 then returns 0.
- Write 0xDEADBEEF to address 3: `write_dn` pulses 3 cycles after the request; a read of address 3 returns 0xDEADBEEF with `addr`=3 driven during `read_dn`.
- Read with `halt_q`=1 and `rw_halt`=1: no busy, no `read_dn`. The same read repeated with `rw_halt`=`z` completes normally.
- `read_q`=`write_q`=1, address 7, data 0x11: `bus_err` pulses, `write_dn` asserts, a later read of 7 returns 0x11.
- Write to address 0x100 with `DEPTH`=64: `write_dn` and `bus_err` pulse; a read of 0x100 returns 0.
- `rst` asserted during WAIT of a write to address 9: no `write_dn`; after CLEAR, a read of 9 returns 0.

Source files
------------

// File: rtl/reg_bus_responder_pkg.sv
// Shared bus widths and responder state encoding for the register/memory
// request protocol.
package reg_bus_responder_pkg;

    localparam int ADDR_SIZE = 16;
    localparam int DATA_SIZE = 32;

    typedef enum logic [2:0] {
        RSP_CLEAR = 3'd0,
        RSP_IDLE  = 3'd1,
        RSP_WAIT  = 3'd2,
        RSP_DONE  = 3'd3,
        RSP_GAP   = 3'd4
    } rsp_state_e;

endpackage

// File: rtl/reg_bus_responder_reg_store.sv
// Word store for the bus responder: single-port RAM, write enable,
// registered read-before-write output.
module reg_store
    import reg_bus_responder_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [IDX_W-1:0]     i_addr,
    input  logic [DATA_SIZE-1:0] i_wdata,
    output logic [DATA_SIZE-1:0] o_rdata
);

    logic [DATA_SIZE-1:0] r_mem [DEPTH];
    logic [DATA_SIZE-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/reg_bus_responder.sv
// Bus-side responder: accepts read/write requests, serves them from a local
// store after a programmable wait and answers with an address-tagged done.
module reg_bus_responder
    import reg_bus_responder_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 read_q,
    input  logic                 write_q,
    input  logic                 halt_q,
    input  logic                 rw_halt,
    inout  logic [ADDR_SIZE-1:0] addr,
    inout  logic [DATA_SIZE-1:0] data,
    output logic                 read_dn,
    output logic                 write_dn,
    output logic                 is_bus_busy,
    output logic                 bus_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

    rsp_state_e            r_state, w_state_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_clr_idx;
    logic [ADDR_SIZE-1:0]  r_addr;
    logic [DATA_SIZE-1:0]  r_data;
    logic                  r_is_rd, r_oor;
    logic                  r_read_dn, r_write_dn, r_busy, r_bus_err;

    logic w_rd_req, w_wr_req, w_req, w_cancel, w_accept, w_in_oor;
    logic w_op_rd, w_op_oor, w_entering_done;
    logic w_busy_next, w_read_dn_next, w_write_dn_next, w_bus_err_next;
    logic                  w_mem_we;
    logic [IDX_W-1:0]      w_mem_addr;
    logic [DATA_SIZE-1:0]  w_mem_wdata, w_mem_rdata;

    // Floating or unknown request lines count as "no request".
    assign w_rd_req = (read_q === 1'b1);
    assign w_wr_req = (write_q === 1'b1);
    assign w_req    = w_rd_req || w_wr_req;
    assign w_cancel = w_rd_req && !w_wr_req && (halt_q === 1'b1) && (rw_halt === 1'b1);
    assign w_accept = (r_state == RSP_IDLE) && w_req && !w_cancel;

    generate
        if (IDX_W < ADDR_SIZE) begin : g_oor
            assign w_in_oor = |addr[ADDR_SIZE-1:IDX_W];
        end else begin : g_no_oor
            assign w_in_oor = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RSP_CLEAR;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RSP_CLEAR: if (r_clr_idx == IDX_W'(DEPTH - 1)) w_state_next = RSP_IDLE;
            RSP_IDLE:  if (w_accept) w_state_next = (WAIT_CYCLES == 0) ? RSP_DONE : RSP_WAIT;
            RSP_WAIT:  if (r_cnt == CNT_W'(1)) w_state_next = RSP_DONE;
            RSP_DONE:  w_state_next = RSP_GAP;
            RSP_GAP:   w_state_next = RSP_IDLE;
            default:   w_state_next = RSP_CLEAR;
        endcase
    end

    // Outputs are registered, so they are computed from the state being entered.
    always_comb begin
        w_op_rd         = (r_state == RSP_IDLE) ? !w_wr_req : r_is_rd;
        w_op_oor        = (r_state == RSP_IDLE) ? w_in_oor : r_oor;
        w_entering_done = (w_state_next == RSP_DONE);
        w_busy_next     = (w_state_next != RSP_IDLE) && (w_state_next != RSP_GAP);
        w_read_dn_next  = w_entering_done && w_op_rd;
        w_write_dn_next = w_entering_done && !w_op_rd;
        w_bus_err_next  = (w_entering_done && w_op_oor)
                       || ((r_state == RSP_IDLE) && w_rd_req && w_wr_req)
                       || (((r_state == RSP_CLEAR) || (r_state == RSP_WAIT)
                            || (r_state == RSP_DONE)) && w_req);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_read_dn  <= 1'b0;
            r_write_dn <= 1'b0;
            r_bus_err  <= 1'b0;
            r_busy     <= 1'b1;
            r_clr_idx  <= '0;
        end else begin
            r_read_dn  <= w_read_dn_next;
            r_write_dn <= w_write_dn_next;
            r_bus_err  <= w_bus_err_next;
            r_busy     <= w_busy_next;
            if (r_state == RSP_CLEAR) begin
                r_clr_idx <= r_clr_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr  <= addr;
            r_data  <= data;
            r_is_rd <= !w_wr_req;
            r_oor   <= w_in_oor;
            r_cnt   <= CNT_W'(WAIT_CYCLES);
        end else if (r_state == RSP_WAIT) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // In IDLE the RAM looks up the live bus address so the word is ready even
    // when the wait is zero; the write commits at the end of DONE unless reset.
    always_comb begin
        w_mem_we    = !rst && ((r_state == RSP_CLEAR)
                   || ((r_state == RSP_DONE) && !r_is_rd && !r_oor));
        w_mem_wdata = (r_state == RSP_CLEAR) ? '0 : r_data;
        if (r_state == RSP_CLEAR) begin
            w_mem_addr = r_clr_idx;
        end else if (r_state == RSP_IDLE) begin
            w_mem_addr = addr[IDX_W-1:0];
        end else begin
            w_mem_addr = r_addr[IDX_W-1:0];
        end
    end

    reg_store #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_store (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_addr  (w_mem_addr),
        .i_wdata (w_mem_wdata),
        .o_rdata (w_mem_rdata)
    );

    assign addr = (r_state == RSP_DONE) ? r_addr : 'z;
    assign data = ((r_state == RSP_DONE) && r_is_rd) ? (r_oor ? '0 : w_mem_rdata) : 'z;

    assign read_dn     = r_read_dn;
    assign write_dn    = r_write_dn;
    assign is_bus_busy = r_busy;
    assign bus_err     = r_bus_err;

endmodule
